// File: rtl/stack_alu_pkg.sv
// Shared encodings for the stack ALU and its RPN sequencer:
// ALU opcodes, token kinds and the sequencer state enum.
package stack_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] TK_NUM = 2'b00;
    localparam logic [1:0] TK_ADD = 2'b01;
    localparam logic [1:0] TK_MUL = 2'b10;
    localparam logic [1:0] TK_END = 2'b11;

    typedef enum logic [2:0] {
        IDLE, PUSH, OP, POP, PUSHR, GAP, DRAIN, DONE
    } state_t;

endpackage

// File: rtl/stack_alu_sequencer.sv
// Turns an RPN token stream into push/pop/add/mul commands for the stack ALU,
// folding each operator result back onto the stack and reporting the final value.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int n         = 8,
    parameter int MAX_DEPTH = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [1:0]   tok_kind,
    input  logic [n-1:0] tok_data,
    output logic [n-1:0] alu_input_data,
    output logic [2:0]   alu_opcode,
    input  logic [n-1:0] alu_output_data,
    input  logic         alu_overflow,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [n-1:0] res_data,
    output logic         res_ovf,
    output logic         res_err
);

    localparam int DW = $clog2(MAX_DEPTH + 1);

    state_t         r_state, r_ret;
    logic [DW-1:0]  r_depth;
    logic [n-1:0]   r_din, r_result, r_top, r_res_data;
    logic [2:0]     r_op;
    logic           r_err, r_ovf, r_second, r_first;
    logic           r_res_valid, r_res_ovf, r_res_err;
    logic           w_accept;

    // Gating with RST_N keeps ready low while reset is held even though state is IDLE.
    assign tok_ready      = (r_state == IDLE) & RST_N;
    assign w_accept       = tok_valid & (r_state == IDLE);
    assign alu_input_data = r_din;
    assign alu_opcode     = r_op;
    assign res_valid      = r_res_valid;
    assign res_data       = r_res_data;
    assign res_ovf        = r_res_ovf;
    assign res_err        = r_res_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_ret       <= IDLE;
            r_depth     <= '0;
            r_din       <= '0;
            r_result    <= '0;
            r_top       <= '0;
            r_op        <= OP_NOP;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_second    <= 1'b0;
            r_first     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    case (tok_kind)
                        TK_NUM: if (r_depth == DW'(MAX_DEPTH)) begin
                            r_err   <= 1'b1;
                            r_state <= GAP;
                            r_ret   <= IDLE;
                        end else begin
                            r_op    <= OP_PUSH;
                            r_din   <= tok_data;
                            r_state <= PUSH;
                        end
                        TK_ADD, TK_MUL: if (r_depth < DW'(2)) begin
                            r_err   <= 1'b1;
                            r_state <= GAP;
                            r_ret   <= IDLE;
                        end else begin
                            r_op    <= (tok_kind == TK_ADD) ? OP_ADD : OP_MUL;
                            r_state <= OP;
                        end
                        default: begin
                            // Leading GAP lets the drain loop issue every POP from GAP.
                            r_err   <= r_err | (r_depth != DW'(1));
                            r_top   <= '0;
                            r_first <= 1'b1;
                            r_state <= GAP;
                            r_ret   <= (r_depth == '0) ? DONE : DRAIN;
                        end
                    endcase
                end
                PUSH: begin
                    r_op    <= OP_NOP;
                    r_depth <= r_depth + 1'b1;
                    r_state <= GAP;
                    r_ret   <= IDLE;
                end
                OP: begin
                    r_result <= alu_output_data;
                    r_ovf    <= r_ovf | (alu_overflow === 1'b1);
                    r_op     <= OP_NOP;
                    r_second <= 1'b0;
                    r_state  <= GAP;
                    r_ret    <= POP;
                end
                POP: begin
                    r_op     <= OP_NOP;
                    r_depth  <= r_depth - 1'b1;
                    r_second <= 1'b1;
                    r_state  <= GAP;
                    r_ret    <= r_second ? PUSHR : POP;
                end
                PUSHR: begin
                    r_op    <= OP_NOP;
                    r_depth <= r_depth + 1'b1;
                    r_state <= GAP;
                    r_ret   <= IDLE;
                end
                DRAIN: begin
                    if (r_first) r_top <= alu_output_data;
                    r_first <= 1'b0;
                    r_op    <= OP_NOP;
                    r_depth <= r_depth - 1'b1;
                    r_state <= GAP;
                    r_ret   <= (r_depth == DW'(1)) ? DONE : DRAIN;
                end
                GAP: begin
                    r_state <= r_ret;
                    case (r_ret)
                        POP, DRAIN: r_op <= OP_POP;
                        PUSHR: begin
                            r_op  <= OP_PUSH;
                            r_din <= r_result;
                        end
                        DONE: begin
                            r_res_valid <= 1'b1;
                            r_res_data  <= r_top;
                            r_res_ovf   <= r_ovf;
                            r_res_err   <= r_err;
                        end
                        default: ;
                    endcase
                end
                DONE: if (res_ready) begin
                    r_err       <= 1'b0;
                    r_ovf       <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_res_data  <= '0;
                    r_res_ovf   <= 1'b0;
                    r_res_err   <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack ALU, table vectors, corner
// sequences and random RPN streams checked against a queue-based reference.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    localparam int MAXD = 16;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } tok_t;

    typedef struct packed {
        logic [3:0]        n;
        logic [0:7][9:0]   c;
        logic [7:0]        res;
        logic              ovf;
        logic              err;
    } vec_t;

    localparam logic [9:0] A = 10'h100, M = 10'h200, E = 10'h300, Z = 10'h000;

    logic       CLK = 1'b0, RST_N = 1'b0;
    logic       tok_valid = 1'b0, tok_ready, res_ready = 1'b0;
    logic [1:0] tok_kind = 2'b00;
    logic [7:0] tok_data = 8'h00, alu_input_data, res_data;
    logic [7:0] alu_output_data = 8'h00;
    logic       alu_overflow = 1'b0;
    logic [2:0] alu_opcode;
    logic       res_valid, res_ovf, res_err;

    int n_chk = 0, n_err = 0, nop_viol = 0;
    logic [7:0]  astk[$];
    logic [2:0]  prev_op = OP_NOP;
    logic [10:0] act_cmds[$], exp_cmds[$];
    int          exp_lat[$];
    tok_t        tq[$];
    vec_t        vt[0:7];

    stack_alu_sequencer #(.n(8), .MAX_DEPTH(MAXD)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
        .alu_input_data(alu_input_data), .alu_opcode(alu_opcode),
        .alu_output_data(alu_output_data), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_err(res_err)
    );

    always #5 CLK = ~CLK;

    // Stack ALU: add/mul read the two top entries (signed overflow), pop shows the top.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] t, input logic [7:0] u);
        int r;
        r = 0;
        case (op)
            OP_ADD:  r = int'($signed(t)) + int'($signed(u));
            OP_MUL:  r = int'($signed(t)) * int'($signed(u));
            OP_POP:  return {1'b0, t};
            default: return 9'd0;
        endcase
        return {(r > 127 || r < -128), r[7:0]};
    endfunction

    always @(negedge CLK)
        {alu_overflow, alu_output_data} <= alu_f(alu_opcode,
            (astk.size() > 0) ? astk[astk.size()-1] : 8'h00,
            (astk.size() > 1) ? astk[astk.size()-2] : 8'h00);

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            astk.delete();
            prev_op <= OP_NOP;
        end else begin
            if (alu_opcode != OP_NOP && prev_op != OP_NOP) nop_viol <= nop_viol + 1;
            prev_op <= alu_opcode;
            if (alu_opcode != OP_NOP)
                act_cmds.push_back({alu_opcode, (alu_opcode == OP_PUSH) ? alu_input_data : 8'h00});
            if (alu_opcode == OP_PUSH) astk.push_back(alu_input_data);
            else if (alu_opcode == OP_POP && astk.size() > 0) void'(astk.pop_back());
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference: evaluate the token queue with a plain value stack.
    task automatic model_run(output logic [7:0] res, output logic ovf, output logic err);
        logic [7:0] s[$];
        logic [7:0] a, b;
        int r, d;
        exp_cmds.delete();
        exp_lat.delete();
        res = 8'h00; ovf = 1'b0; err = 1'b0;
        foreach (tq[i]) begin
            if (tq[i].kind == TK_NUM) begin
                if (s.size() >= MAXD) begin
                    err = 1'b1; exp_lat.push_back(1);
                end else begin
                    s.push_back(tq[i].data);
                    exp_cmds.push_back({OP_PUSH, tq[i].data});
                    exp_lat.push_back(2);
                end
            end else if (tq[i].kind == TK_END) begin
                d = s.size();
                if (d != 1) err = 1'b1;
                if (d > 0) res = s[d-1];
                for (int k = 0; k < d; k++) exp_cmds.push_back({OP_POP, 8'h00});
                exp_lat.push_back(2 * d + 1);
                s.delete();
            end else if (s.size() < 2) begin
                err = 1'b1; exp_lat.push_back(1);
            end else begin
                a = s.pop_back();
                b = s.pop_back();
                r = (tq[i].kind == TK_ADD) ? int'($signed(a)) + int'($signed(b))
                                           : int'($signed(a)) * int'($signed(b));
                if (r > 127 || r < -128) ovf = 1'b1;
                s.push_back(r[7:0]);
                exp_cmds.push_back({(tq[i].kind == TK_ADD) ? OP_ADD : OP_MUL, 8'h00});
                exp_cmds.push_back({OP_POP, 8'h00});
                exp_cmds.push_back({OP_POP, 8'h00});
                exp_cmds.push_back({OP_PUSH, r[7:0]});
                exp_lat.push_back(8);
            end
        end
    endtask

    task automatic drive_tok(input tok_t t, output bit ok);
        int w;
        tok_valid = 1'b1; tok_kind = t.kind; tok_data = t.data;
        w = 0;
        while (!tok_ready && w < 100) begin @(negedge CLK); w++; end
        ok = tok_ready;
        chk("tok_accept", int'(tok_ready), 1);
        if (ok) @(posedge CLK);
        #1 tok_valid = 1'b0; tok_kind = 2'b00; tok_data = 8'h00;
    endtask

    // Called just after a negedge; returns just after a negedge once the result is consumed.
    task automatic run_expr(input int hold, input bit use_tbl,
                            input logic [7:0] tres, input logic tovf, input logic terr);
        logic [7:0] mres;
        logic movf, merr;
        int base, lat, nc;
        bit ok, is_end;
        model_run(mres, movf, merr);
        base = act_cmds.size();
        foreach (tq[k]) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge CLK);
            drive_tok(tq[k], ok);
            if (!ok) return;
            is_end = (tq[k].kind == TK_END);
            lat = 0;
            while (lat <= 100) begin
                @(negedge CLK);
                if (is_end ? res_valid : tok_ready) break;
                lat++;
            end
            chk("latency", lat, exp_lat[k]);
        end
        chk("res_valid", int'(res_valid), 1);
        chk("res_data", int'(res_data), int'(mres));
        chk("res_ovf", int'(res_ovf), int'(movf));
        chk("res_err", int'(res_err), int'(merr));
        if (use_tbl) begin
            chk("tbl_data", int'(res_data), int'(tres));
            chk("tbl_ovf", int'(res_ovf), int'(tovf));
            chk("tbl_err", int'(res_err), int'(terr));
        end
        nc = act_cmds.size() - base;
        chk("trace_len", nc, exp_cmds.size());
        for (int i = 0; i < nc && i < exp_cmds.size(); i++)
            chk("trace_cmd", int'(act_cmds[base+i]), int'(exp_cmds[i]));
        repeat (hold) begin
            @(negedge CLK);
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_data", int'(res_data), int'(mres));
            chk("hold_flags", int'({res_ovf, res_err}), int'({movf, merr}));
            chk("hold_tok_ready", int'(tok_ready), 0);
        end
        res_ready = 1'b1;
        @(posedge CLK);
        #1 res_ready = 1'b0;
        @(negedge CLK);
        chk("clr_valid", int'(res_valid), 0);
        chk("clr_data", int'(res_data), 0);
        chk("clr_flags", int'({res_ovf, res_err}), 0);
        chk("ready_back", int'(tok_ready), 1);
    endtask

    task automatic load_vec(input int i);
        tq.delete();
        for (int j = 0; j < int'(vt[i].n); j++) tq.push_back(tok_t'(vt[i].c[j]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tok_t t;
        bit   ok;
        int   w;
        vt[0] = '{4'd4, {10'h003, 10'h004, A, E, Z, Z, Z, Z}, 8'h07, 1'b0, 1'b0};
        vt[1] = '{4'd6, {10'h002, 10'h003, 10'h004, M, A, E, Z, Z}, 8'h0E, 1'b0, 1'b0};
        vt[2] = '{4'd4, {10'h064, 10'h064, A, E, Z, Z, Z, Z}, 8'hC8, 1'b1, 1'b0};
        vt[3] = '{4'd3, {10'h005, A, E, Z, Z, Z, Z, Z}, 8'h05, 1'b0, 1'b1};
        vt[4] = '{4'd1, {E, Z, Z, Z, Z, Z, Z, Z}, 8'h00, 1'b0, 1'b1};
        vt[5] = '{4'd4, {10'h003, 10'h004, 10'h005, E, Z, Z, Z, Z}, 8'h05, 1'b0, 1'b1};
        vt[6] = '{4'd4, {10'h0C8, 10'h002, M, E, Z, Z, Z, Z}, 8'h90, 1'b0, 1'b0};
        vt[7] = '{4'd4, {10'h010, 10'h010, M, E, Z, Z, Z, Z}, 8'h00, 1'b1, 1'b0};

        #1;
        chk("rst_tok_ready", int'(tok_ready), 0);
        chk("rst_opcode", int'(alu_opcode), 0);
        chk("rst_din", int'(alu_input_data), 0);
        chk("rst_res", int'({res_valid, res_ovf, res_err, res_data}), 0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_release_ready", int'(tok_ready), 1);

        for (int i = 0; i < 8; i++) begin
            load_vec(i);
            run_expr($urandom_range(0, 2), 1'b1, vt[i].res, vt[i].ovf, vt[i].err);
        end

        // Overfill: seventeenth operand is dropped, result held for five cycles.
        tq.delete();
        for (int i = 0; i <= MAXD; i++) begin
            t.kind = TK_NUM; t.data = 8'(i + 1); tq.push_back(t);
        end
        t.kind = TK_END; t.data = 8'h00; tq.push_back(t);
        run_expr(5, 1'b1, 8'h10, 1'b0, 1'b1);

        // Reset during the first POP of a multiply sequence.
        t.kind = TK_NUM; t.data = 8'h02; drive_tok(t, ok);
        @(negedge CLK);
        t.data = 8'h03; drive_tok(t, ok);
        @(negedge CLK);
        t.kind = TK_MUL; t.data = 8'h00; drive_tok(t, ok);
        w = 0;
        while (alu_opcode != OP_POP && w < 50) begin @(negedge CLK); w++; end
        chk("pop_seen", int'(alu_opcode), int'(OP_POP));
        RST_N = 1'b0;
        #1;
        chk("mid_rst_tok_ready", int'(tok_ready), 0);
        chk("mid_rst_opcode", int'(alu_opcode), 0);
        chk("mid_rst_din", int'(alu_input_data), 0);
        chk("mid_rst_res", int'({res_valid, res_ovf, res_err, res_data}), 0);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", int'(tok_ready), 1);
        chk("post_rst_opcode", int'(alu_opcode), 0);
        load_vec(0);
        run_expr(1, 1'b1, vt[0].res, vt[0].ovf, vt[0].err);

        for (int e = 0; e < 30; e++) begin
            int nt, r;
            tq.delete();
            nt = $urandom_range(0, 10);
            for (int k = 0; k < nt; k++) begin
                r = $urandom_range(0, 9);
                t.data = 8'h00;
                if (r < 6) begin
                    t.kind = TK_NUM;
                    t.data = (r < 3) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                end else t.kind = (r < 8) ? TK_ADD : TK_MUL;
                tq.push_back(t);
            end
            t.kind = TK_END; t.data = 8'h00; tq.push_back(t);
            run_expr($urandom_range(0, 3), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        chk("nop_gap", nop_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stack_alu_sequencer.md
# stack_alu_sequencer

- Initiator-side controller for the stack-based ALU.
- Accepts a postfix (RPN) token stream over a valid/ready handshake and issues push, pop, add and multiply commands on the ALU's `input_data`/`opcode` port.
- The ALU's add and multiply leave both operands on the stack, so for every operator this block captures the result, pops both operands and pushes the result back.
- Returns the final value with overflow and error flags on a second valid/ready handshake.

## Interface
- `n`, 8: data width; matches the ALU.
- `MAX_DEPTH`, 16: maximum number of entries the sequencer lets sit on the ALU stack.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `tok_valid`  in  1  token offered.
- `tok_ready`  out  1  token accepted on a cycle where valid and ready are both high.
- `tok_kind`  in  2  token type: 00 operand, 01 add, 10 mul, 11 end.
- `tok_data`  in  n  operand value; ignored for other kinds.
- `alu_input_data`  out  n  data for a push command.
- `alu_opcode`  out  3  ALU command.
- `alu_output_data`  in  n  ALU result.
- `alu_overflow`  in  1  ALU overflow flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when valid and ready are both high.
- `res_data`  out  n  final value of the expression.
- `res_ovf`  out  1  sticky overflow accumulated over the expression.
- `res_err`  out  1  malformed expression.

## Operation
- Each ALU command is driven for exactly one cycle and is always followed by at least one NOP cycle (`opcode` = 3'b000).
- A GAP state with a return-state register inserts the NOP cycle.
- Reset values:
  - state = IDLE, depth = 0.
  - `alu_opcode` = 000, `alu_input_data` = 0.
  - `tok_ready` = 0 during reset, then 1 in IDLE.
  - `res_valid`, `res_data`, `res_ovf`, `res_err` all 0.
- IDLE: `tok_ready` = 1; the accepted token is registered.
- Operand token:
  - depth < MAX_DEPTH: PUSH(`tok_data`) → GAP → IDLE; depth +1.
  - depth == MAX_DEPTH: token dropped, `err` set, no ALU command.
- Add/mul token:
  - depth < 2: `err` set, no ALU command.
  - Otherwise the sequence is OP → GAP → POP → GAP → POP → GAP → PUSH(result) → GAP → IDLE.
  - `alu_output_data` is captured at the rising edge that ends the OP cycle.
  - `alu_overflow === 1'b1` at that edge ORs into sticky `ovf`; an X/Z value counts as 0.
  - Net depth change is −1.
- End token:
  - DRAIN: POP → GAP, repeated `depth` times. The first POP's output is captured as the result. Afterwards depth = 0 and the ALU stack is empty.
  - `res_err` = `err` | (depth at end ≠ 1).
  - `res_data` = captured top when depth ≥ 1, otherwise 0.
  - `res_ovf` = `ovf`.
  - Then DONE.
- DONE: `res_valid` = 1 and `tok_ready` = 0. On handshake: `err` and `ovf` clear, all `res_*` outputs return to 0, next state IDLE.
- Errors never abort the stream; they are reported only at the end token.
- Arithmetic: the ALU does the arithmetic. The pushed result is the n-bit truncated ALU output.
- States: IDLE, PUSH, OP, POP, PUSHR, GAP, DRAIN, DONE.

## Timing
- Operand token: 2 cycles from acceptance back to `tok_ready`.
- Operator token: 8 cycles.
- Erroneous token: 1 cycle.
- End token: 2·depth + 1 cycles to `res_valid`.
- `res_valid` stays high with `res_*` stable until `res_ready`. Back-to-back expressions are allowed the cycle after the handshake.
- `tok_ready` is low in every state except IDLE. `tok_valid` may be held indefinitely.
- Reset asserted mid-sequence: everything returns to reset values immediately. The ALU stack is not reset; system-level requirement: the ALU must be re-initialised alongside this block. No recovery is attempted.

## Structure
- Shared package `stack_alu_pkg` holds:
  - Opcode constants: OP_ADD = 100, OP_MUL = 101, OP_PUSH = 110, OP_POP = 111, OP_NOP = 000.
  - Token-kind encodings.
  - The state enum.
- Depth counter width is $clog2(MAX_DEPTH+1).
- Single module, one FSM; no sub-module is warranted.

## Test plan
- Tokens 3, 4, +, end → ALU sees push 3, push 4, add, pop, pop, push 7, pop; result 7, ovf 0, err 0.
- Tokens 2, 3, 4, *, +, end → result 14 (0x0E), ovf 0, err 0.
- Tokens 100, 100, +, end → result 0xC8, ovf 1, err 0.
- Tokens 5, +, end → operator makes no ALU command; result 5, err 1.
- Push MAX_DEPTH+1 operands, then end → last operand dropped, 16 drain pops, err 1. Hold `res_ready` low 5 cycles → `res_*` stable and `tok_ready` stays 0.
- Assert `RST_N` low during the first POP of a multiply sequence → all outputs at reset values asynchronously; `tok_ready` = 1 in the first cycle after release.
